fft_ctrl: RTL and testbench

//  Sequencer for an in-place radix-2 DIF FFT built around the 1-cycle registered butterfly.
//  Per stage: generates sample-RAM read/write address pairs, twiddle-ROM address and butterfly enable.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_ctrl_delay.sv | 31 +++
 rtl/fft_ctrl.sv | 141 ++++++++++++++
 tb/tb_fft_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT sequencer: default sizing,
// the sequencer state encoding and a constant-friendly ceil(log2) helper.
package fft_pkg;

   localparam int LOG2N_DEF      = 10;
   localparam int RAM_RD_LAT_DEF = 1;
   localparam int BFLY_LAT_DEF   = 1;
   localparam int N              = 2 ** LOG2N_DEF;
   localparam int PIPE           = RAM_RD_LAT_DEF + BFLY_LAT_DEF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } fft_state_t;

   // Never returns less than 1 so the result can always size a vector.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth shift register with synchronous clear, used to align the
// butterfly enable and RAM write strobe/addresses with the read pipeline.
module ctrl_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] taps [DEPTH];

   // Clearing on reset guarantees no stale write strobe escapes after an abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps[i] <= '0;
         end
      end else begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

   assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT: drives RAM read
// pairs, twiddle address, butterfly enable and the delayed write-back pairs.
module fft_ctrl
   import fft_pkg::*;
#(
   parameter int LOG2N      = LOG2N_DEF,
   parameter int RAM_RD_LAT = RAM_RD_LAT_DEF,
   parameter int BFLY_LAT   = BFLY_LAT_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [clog2(LOG2N)-1:0]    stage,
   output logic                       rd_en,
   output logic [LOG2N-1:0]           rd_addr_a,
   output logic [LOG2N-1:0]           rd_addr_b,
   output logic [LOG2N-2:0]           tw_addr,
   output logic                       bf_enable,
   output logic                       wr_en,
   output logic [LOG2N-1:0]           wr_addr_a,
   output logic [LOG2N-1:0]           wr_addr_b
);

   localparam int SW       = clog2(LOG2N);
   localparam int KW       = LOG2N - 1;
   localparam int PIPE_LAT = RAM_RD_LAT + BFLY_LAT;
   localparam int CW       = clog2(PIPE_LAT + 1);

   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
   localparam logic [CW-1:0] D_LAST = CW'(PIPE_LAT - 1);

   fft_state_t      state, state_n;
   logic [SW-1:0]   stage_q, stage_n;
   logic [KW-1:0]   k, k_n;
   logic [CW-1:0]   dcnt, dcnt_n;

   logic [SW-1:0]    shr;
   logic [LOG2N-1:0] kx, span, jmask, j, base_a;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         stage_q <= '0;
         k       <= '0;
         dcnt    <= '0;
      end else begin
         state   <= state_n;
         stage_q <= stage_n;
         k       <= k_n;
         dcnt    <= dcnt_n;
      end
   end

   // DRAIN holds off reads for the full pipe so every write of a stage lands
   // before the next stage reads the same locations back.
   always_comb begin
      state_n = state;
      stage_n = stage_q;
      k_n     = k;
      dcnt_n  = dcnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               stage_n = '0;
               k_n     = '0;
            end
         end
         RUN: begin
            if (k == K_LAST) begin
               state_n = DRAIN;
               dcnt_n  = '0;
            end else begin
               k_n = k + KW'(1);
            end
         end
         DRAIN: begin
            if (dcnt == D_LAST) begin
               if (stage_q == S_LAST) begin
                  state_n = DONE;
               end else begin
                  state_n = RUN;
                  stage_n = stage_q + SW'(1);
                  k_n     = '0;
               end
            end else begin
               dcnt_n = dcnt + CW'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Base of a pair is k with its low log2(span) bits kept and the group
   // bits doubled, i.e. g*2*span + j without a multiplier.
   always_comb begin
      shr    = S_LAST - stage_q;
      kx     = {1'b0, k};
      span   = LOG2N'(1) << shr;
      jmask  = span - LOG2N'(1);
      j      = kx & jmask;
      base_a = ((kx & ~jmask) << 1) | j;
   end

   assign rd_en     = (state == RUN);
   assign rd_addr_a = rd_en ? base_a : '0;
   assign rd_addr_b = rd_en ? (base_a | span) : '0;
   assign tw_addr   = rd_en ? (j[LOG2N-2:0] << stage_q) : '0;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign stage     = stage_q;

   ctrl_delay_line #(
      .WIDTH (1 + 2 * LOG2N),
      .DEPTH (PIPE_LAT)
   ) u_wr_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({rd_en, rd_addr_a, rd_addr_b}),
      .dout ({wr_en, wr_addr_a, wr_addr_b})
   );

   ctrl_delay_line #(
      .WIDTH (1),
      .DEPTH (RAM_RD_LAT)
   ) u_bf_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_en),
      .dout (bf_enable)
   );

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at N=8: address sequence, start filtering,
// mid-run reset and a RAM_RD_LAT=2 variant with hand-computed tables.
module tb_fft_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;

   always #5 clk = ~clk;

   logic       busy, done, rd_en, bf_enable, wr_en;
   logic [1:0] stage, tw_addr;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

   logic       busy2, done2, rd_en2, bf_enable2, wr_en2;
   logic [1:0] stage2, tw_addr2;
   logic [2:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;

   fft_ctrl #(.LOG2N(3), .RAM_RD_LAT(1), .BFLY_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_addr(tw_addr), .bf_enable(bf_enable), .wr_en(wr_en),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   fft_ctrl #(.LOG2N(3), .RAM_RD_LAT(2), .BFLY_LAT(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .stage(stage2), .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
      .tw_addr(tw_addr2), .bf_enable(bf_enable2), .wr_en(wr_en2),
      .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
   );

   int passCount = 0;
   int checkCount = 0;

   // Read pairs of stages 0,1,2 in issue order, with their twiddle indices.
   int expA [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
   int expB [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
   int expT [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, return at mid-cycle.
   task automatic applyStimulus(input logic s, input logic s2, input logic r);
      @(posedge clk);
      #1;
      start  = s;
      start2 = s2;
      rst    = r;
      @(negedge clk);
   endtask

   // Table index of the read issued c cycles after start, or -1 if none.
   function automatic int readIdx(input int c, input int period);
      int k;
      k = (c - 1) % period;
      if (c < 1 || c > 3 * period || k >= 4) return -1;
      return ((c - 1) / period) * 4 + k;
   endfunction

   task automatic checkCycle1(input int c);
      int r, b, w;
      r = readIdx(c, 6);
      b = readIdx(c - 1, 6);
      w = readIdx(c - 2, 6);
      checkOutput($sformatf("c%0d rd_en", c), int'(rd_en), int'(r >= 0));
      if (r >= 0) begin
         checkOutput($sformatf("c%0d rd_addr_a", c), int'(rd_addr_a), expA[r]);
         checkOutput($sformatf("c%0d rd_addr_b", c), int'(rd_addr_b), expB[r]);
         checkOutput($sformatf("c%0d tw_addr", c), int'(tw_addr), expT[r]);
      end
      checkOutput($sformatf("c%0d bf_enable", c), int'(bf_enable), int'(b >= 0));
      checkOutput($sformatf("c%0d wr_en", c), int'(wr_en), int'(w >= 0));
      if (w >= 0) begin
         checkOutput($sformatf("c%0d wr_addr_a", c), int'(wr_addr_a), expA[w]);
         checkOutput($sformatf("c%0d wr_addr_b", c), int'(wr_addr_b), expB[w]);
      end
      checkOutput($sformatf("c%0d busy", c), int'(busy), int'(c >= 1 && c <= 18));
      checkOutput($sformatf("c%0d done", c), int'(done), int'(c == 19));
      if (c <= 18) begin
         checkOutput($sformatf("c%0d stage", c), int'(stage), (c - 1) / 6);
      end
   endtask

   task automatic runSequence(input bit noisy);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 21; c++) begin
         applyStimulus(noisy && (c == 5 || c == 19), 1'b0, 1'b0);
         checkCycle1(c);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " rd_en"}, int'(rd_en), 0);
      checkOutput({tag, " wr_en"}, int'(wr_en), 0);
      checkOutput({tag, " bf_enable"}, int'(bf_enable), 0);
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " done"}, int'(done), 0);
      checkOutput({tag, " stage"}, int'(stage), 0);
      checkOutput({tag, " rd_addr_a"}, int'(rd_addr_a), 0);
      checkOutput({tag, " rd_addr_b"}, int'(rd_addr_b), 0);
      checkOutput({tag, " tw_addr"}, int'(tw_addr), 0);
      checkOutput({tag, " wr_addr_a"}, int'(wr_addr_a), 0);
      checkOutput({tag, " wr_addr_b"}, int'(wr_addr_b), 0);
   endtask

   initial begin
      int r, b, w;

      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkAllZero("reset");
      checkOutput("reset busy2", int'(busy2), 0);
      checkOutput("reset wr_en2", int'(wr_en2), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] full transform, N=8");
      runSequence(1'b0);
      $display("[TB] starts during DRAIN and DONE must be ignored");
      runSequence(1'b1);
      $display("[TB] clean restart after ignored starts");
      runSequence(1'b0);

      $display("[TB] reset in the middle of stage 1");
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkCycle1(c);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkCycle1(8);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkAllZero("abort c9");
      for (int c = 10; c <= 14; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("abort c%0d wr_en", c), int'(wr_en), 0);
         checkOutput($sformatf("abort c%0d rd_en", c), int'(rd_en), 0);
         checkOutput($sformatf("abort c%0d busy", c), int'(busy), 0);
      end

      $display("[TB] RAM read latency 2, pipe 3");
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 23; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         r = readIdx(c, 7);
         b = readIdx(c - 2, 7);
         w = readIdx(c - 3, 7);
         checkOutput($sformatf("lat2 c%0d rd_en", c), int'(rd_en2), int'(r >= 0));
         if (r >= 0) begin
            checkOutput($sformatf("lat2 c%0d rd_addr_a", c), int'(rd_addr_a2), expA[r]);
            checkOutput($sformatf("lat2 c%0d tw_addr", c), int'(tw_addr2), expT[r]);
         end
         checkOutput($sformatf("lat2 c%0d bf_enable", c), int'(bf_enable2), int'(b >= 0));
         checkOutput($sformatf("lat2 c%0d wr_en", c), int'(wr_en2), int'(w >= 0));
         if (w >= 0) begin
            checkOutput($sformatf("lat2 c%0d wr_addr_b", c), int'(wr_addr_b2), expB[w]);
         end
         checkOutput($sformatf("lat2 c%0d busy", c), int'(busy2), int'(c >= 1 && c <= 21));
         checkOutput($sformatf("lat2 c%0d done", c), int'(done2), int'(c == 22));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
